aes_round_iter: RTL

- Iterative AES-128 encryption front end that sits directly upstream of final_round.
- Accepts a plaintext/key pair and applies the initial AddRoundKey plus rounds 1..9, one round per clock, with on-the-fly key expansion.
- Emits the round-10 input state and the round-9 key, which is exactly what final_round consumes on its state_in/key_in with rcon = 8'h36.
- Area-small alternative to the unrolled pipeline; valid/ready handshake on both sides.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_round_comb.sv | 69 ++++++
 rtl/aes_sbox.sv | 23 ++
 rtl/aes_round_iter.sv | 94 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR         = 10;
  localparam logic [7:0]  FINAL_RCON = 8'h36;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_e;

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for key-expansion step idx (1..10); 0 elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus the
// matching key-expansion step; purely combinational.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_next_state,
  output logic [127:0] o_next_rkey
);

  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [31:0]  w_rot;
  logic [31:0]  w_ksub;

  // Byte i of the block lives at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .i_byte(i_state[127 - 8 * i -: 8]),
      .o_byte(w_sub[127 - 8 * i -: 8])
    );
  end

  // RotWord of the last key word, then SubWord.
  assign w_rot = {i_rkey[23:0], i_rkey[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .i_byte(w_rot[31 - 8 * j -: 8]),
      .o_byte(w_ksub[31 - 8 * j -: 8])
    );
  end

  // ShiftRows then MixColumns, column by column.
  always_comb begin
    w_shift = '0;
    w_mix   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[127 - 8 * (4 * c + r) -: 8] = w_sub[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = w_shift[127 - 32 * c -: 8];
      a1 = w_shift[119 - 32 * c -: 8];
      a2 = w_shift[111 - 32 * c -: 8];
      a3 = w_shift[103 - 32 * c -: 8];
      w_mix[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      w_mix[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      w_mix[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      w_mix[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // Key expansion: each word chains from the freshly produced previous word.
  always_comb begin
    o_next_rkey[127:96] = i_rkey[127:96] ^ w_ksub ^ {i_rcon, 24'h0};
    o_next_rkey[95:64]  = i_rkey[95:64] ^ o_next_rkey[127:96];
    o_next_rkey[63:32]  = i_rkey[63:32] ^ o_next_rkey[95:64];
    o_next_rkey[31:0]   = i_rkey[31:0] ^ o_next_rkey[63:32];
  end

  assign o_next_state = w_mix ^ o_next_rkey;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a 256-entry constant table.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  always_comb begin
    o_byte = SboxTable[2047 - 8 * i_byte -: 8];
  end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES-128 front end: initial AddRoundKey plus rounds 1..NR-1, one
// round per clock, handing the round-10 input state and round-9 key downstream.
module aes_round_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);

  fsm_state_e   r_fsm, w_fsm_d;
  logic [3:0]   r_rnd, w_rnd_d;
  logic [127:0] r_state, w_state_d;
  logic [127:0] r_rkey, w_rkey_d;
  logic [127:0] w_round_state;
  logic [127:0] w_round_rkey;
  logic [7:0]   w_rcon;

  assign w_rcon = rcon(r_rnd);

  aes_round_comb u_round (
    .i_state     (r_state),
    .i_rkey      (r_rkey),
    .i_rcon      (w_rcon),
    .o_next_state(w_round_state),
    .o_next_rkey (w_round_rkey)
  );

  // Next-state, handshake and datapath-load decode.
  always_comb begin
    w_fsm_d   = r_fsm;
    w_rnd_d   = r_rnd;
    w_state_d = r_state;
    w_rkey_d  = r_rkey;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        in_ready = rst_n;
      end
      RUN: begin
        w_state_d = w_round_state;
        w_rkey_d  = w_round_rkey;
        w_rnd_d   = r_rnd + 4'd1;
        if (r_rnd == 4'(NR - 1)) begin
          w_fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Combinational on purpose: lets a new job load in the handshake cycle.
        in_ready  = out_ready & rst_n;
        if (out_ready) begin
          w_fsm_d = IDLE;
        end
      end
      default: begin
        w_fsm_d = IDLE;
      end
    endcase
    if (in_valid && in_ready) begin
      w_state_d = plaintext ^ key;
      w_rkey_d  = key;
      w_rnd_d   = 4'd1;
      w_fsm_d   = RUN;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_rnd   <= '0;
      r_state <= '0;
      r_rkey  <= '0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_rnd   <= w_rnd_d;
      r_state <= w_state_d;
      r_rkey  <= w_rkey_d;
    end
  end

  assign state_out = r_state;
  assign key_out   = r_rkey;

endmodule
